// File: rtl/ecc_sed_pkg.sv
// Shared types and helpers for the single-error-detect (SED) parity codec.
// Used by both the encoder and the ecc_sed_decoder receive path.
package ecc_sed_pkg;

  localparam int ECC_SED_DATA_WIDTH = 12;
  localparam int ECC_SED_CW_WIDTH   = ECC_SED_DATA_WIDTH + 1;

  typedef struct packed {
    logic                          parity;
    logic [ECC_SED_DATA_WIDTH-1:0] data;
  } ecc_sed_cw_t;

  typedef enum logic [1:0] {
    BUF_EMPTY,
    BUF_ONE,
    BUF_FULL
  } buf_state_t;

  // Even parity: the parity bit makes the XOR of the whole codeword zero.
  function automatic logic ecc_sed_parity(input logic [ECC_SED_DATA_WIDTH-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/ecc_sed_skid_buf.sv
// Two-entry valid/ready skid buffer: an output register plus one skid entry.
// in_ready is registered, so out_ready has no combinational path to it.
module ecc_sed_skid_buf
  import ecc_sed_pkg::*;
#(
  parameter int WIDTH = ECC_SED_CW_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  buf_state_t       state;
  logic [WIDTH-1:0] skid_data;
  logic             accept;
  logic             pop;

  assign accept = in_valid & in_ready;
  assign pop    = out_valid & out_ready;

  // NOTE: only control state and the visible output register are reset; the
  // skid entry is never read while empty, so it needs no reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= BUF_EMPTY;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      out_data  <= '0;
    end else begin
      case (state)
        BUF_EMPTY: begin
          if (accept) begin
            out_data  <= in_data;
            out_valid <= 1'b1;
            state     <= BUF_ONE;
          end
        end
        BUF_ONE: begin
          if (accept && pop) begin
            out_data <= in_data;
          end else if (accept) begin
            skid_data <= in_data;
            in_ready  <= 1'b0;
            state     <= BUF_FULL;
          end else if (pop) begin
            out_valid <= 1'b0;
            state     <= BUF_EMPTY;
          end
        end
        BUF_FULL: begin
          if (pop) begin
            out_data <= skid_data;
            in_ready <= 1'b1;
            state    <= BUF_ONE;
          end
        end
        default: begin
          state     <= BUF_EMPTY;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/ecc_sed_decoder.sv
// SED parity decoder: checks and strips parity, forwards {err, data} via a skid
// buffer, keeps sticky/saturating error status. ECC_SED_DECODER_DROP_EN drops bad words.
module ecc_sed_decoder
  import ecc_sed_pkg::*;
#(
  parameter int DATA_WIDTH = ECC_SED_DATA_WIDTH,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enc_valid,
  output logic                  enc_ready,
  input  logic [DATA_WIDTH:0]   enc_codeword,
  output logic                  dec_valid,
  input  logic                  dec_ready,
  output logic [DATA_WIDTH-1:0] dec_data,
  output logic                  dec_err,
  output logic                  err_sticky,
  output logic [CNT_WIDTH-1:0]  err_count,
  input  logic                  err_clr
);

  logic                syndrome;
  logic                accept;
  logic                err_accept;
  logic                buf_in_valid;
  logic                fwd_err;
  logic [DATA_WIDTH:0] buf_out;

  assign syndrome   = ^enc_codeword;
  assign accept     = enc_valid & enc_ready;
  assign err_accept = accept & syndrome;

`ifdef ECC_SED_DECODER_DROP_EN
  // Bad words still handshake upstream but never enter the buffer.
  assign buf_in_valid = enc_valid & ~syndrome;
  assign fwd_err      = 1'b0;
`else
  assign buf_in_valid = enc_valid;
  assign fwd_err      = syndrome;
`endif

  ecc_sed_skid_buf #(
    .WIDTH(DATA_WIDTH + 1)
  ) u_skid_buf (
    .clk      (clk),
    .rst      (rst),
    .in_valid (buf_in_valid),
    .in_ready (enc_ready),
    .in_data  ({fwd_err, enc_codeword[DATA_WIDTH-1:0]}),
    .out_valid(dec_valid),
    .out_ready(dec_ready),
    .out_data (buf_out)
  );

  assign dec_data = buf_out[DATA_WIDTH-1:0];
  assign dec_err  = buf_out[DATA_WIDTH];

  // Clear takes effect first, so a coincident erroneous word counts as one.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_sticky <= 1'b0;
      err_count  <= '0;
    end else if (err_clr) begin
      err_sticky <= err_accept;
      err_count  <= err_accept ? CNT_WIDTH'(1) : '0;
    end else if (err_accept) begin
      err_sticky <= 1'b1;
      if (err_count != '1) begin
        err_count <= err_count + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_ecc_sed_decoder.sv
// Directed bench for ecc_sed_decoder with a scoreboard on the output stream;
// a second instance with CNT_WIDTH=2 exercises counter saturation.
module tb_ecc_sed_decoder;
  import ecc_sed_pkg::*;

`ifdef ECC_SED_DECODER_DROP_EN
  localparam bit DROP = 1'b1;
`else
  localparam bit DROP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        enc_valid;
  logic [12:0] enc_codeword;
  logic        dec_ready;
  logic        err_clr;

  logic        enc_ready, dec_valid, dec_err, err_sticky;
  logic [11:0] dec_data;
  logic [15:0] err_count;

  logic        sat_enc_ready, sat_dec_valid, sat_dec_err, sat_err_sticky;
  logic [11:0] sat_dec_data;
  logic [1:0]  sat_err_count;

  int vectors = 0;
  int miscompares = 0;
  logic [12:0] sb_q[$];

  always #5 clk = ~clk;

  ecc_sed_decoder dut (
    .clk(clk), .rst(rst), .enc_valid(enc_valid), .enc_ready(enc_ready),
    .enc_codeword(enc_codeword), .dec_valid(dec_valid), .dec_ready(dec_ready),
    .dec_data(dec_data), .dec_err(dec_err), .err_sticky(err_sticky),
    .err_count(err_count), .err_clr(err_clr)
  );

  ecc_sed_decoder #(.CNT_WIDTH(2)) dut_sat (
    .clk(clk), .rst(rst), .enc_valid(enc_valid), .enc_ready(sat_enc_ready),
    .enc_codeword(enc_codeword), .dec_valid(sat_dec_valid), .dec_ready(dec_ready),
    .dec_data(sat_dec_data), .dec_err(sat_dec_err), .err_sticky(sat_err_sticky),
    .err_count(sat_err_count), .err_clr(err_clr)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [12:0] make_cw(input logic [11:0] data, input bit corrupt);
    ecc_sed_cw_t cw;
    cw.data   = data;
    cw.parity = ecc_sed_parity(data) ^ corrupt;
    return cw;
  endfunction

  // Holds the word valid until accepted, bounded so a stuck enc_ready fails.
  task automatic send(input logic [12:0] cw);
    bit done = 1'b0;
    enc_codeword = cw;
    enc_valid    = 1'b1;
    for (int n = 0; n < 64 && !done; n++) begin
      @(negedge clk);
      done = enc_ready;
      @(posedge clk);
      #1;
    end
    enc_valid = 1'b0;
    check("send_accepted", 32'(done), 1);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: transfers are judged at the negedge before the edge that takes them.
  always @(negedge clk) begin
    if (rst) begin
      sb_q.delete();
    end else begin
      if (dec_valid && dec_ready) begin
        if (sb_q.size() == 0) check("sb_unexpected_word", 32'({dec_err, dec_data}), 32'hFFFF_FFFF);
        else check("sb_word", 32'({dec_err, dec_data}), 32'(sb_q.pop_front()));
      end
      if (enc_valid && enc_ready) begin
        if (!(DROP && (^enc_codeword))) sb_q.push_back({(^enc_codeword) & ~DROP, enc_codeword[11:0]});
      end
    end
  end

  initial begin
    rst = 1'b1; enc_valid = 1'b0; enc_codeword = '0; dec_ready = 1'b1; err_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    check("rst_dec_valid", 32'(dec_valid), 0);
    check("rst_dec_data", 32'(dec_data), 0);
    check("rst_dec_err", 32'(dec_err), 0);
    check("rst_err_sticky", 32'(err_sticky), 0);
    check("rst_err_count", 32'(err_count), 0);
    check("rst_enc_ready", 32'(enc_ready), 1);

    // Clean word, 1-cycle latency
    send(13'h0A5A);
    check("clean_dec_valid", 32'(dec_valid), 1);
    check("clean_dec_data", 32'(dec_data), 'hA5A);
    check("clean_dec_err", 32'(dec_err), 0);
    check("clean_err_count", 32'(err_count), 0);

    // Single-bit error
    send(13'h0001);
    check("err_dec_valid", 32'(dec_valid), DROP ? 0 : 1);
    if (!DROP) check("err_dec_data", 32'(dec_data), 'h001);
    check("err_dec_err", 32'(dec_err), DROP ? 0 : 1);
    check("err_sticky_set", 32'(err_sticky), 1);
    check("err_count_one", 32'(err_count), 1);
    tick();

    // Backpressure: fill both entries, third word held off
    dec_ready = 1'b0;
    send(13'h1001);
    check("bp_ready_after_1", 32'(enc_ready), 1);
    send(13'h0003);
    check("bp_ready_after_2", 32'(enc_ready), 0);
    enc_codeword = 13'h1007;
    enc_valid    = 1'b1;
    repeat (3) tick();
    check("bp_held_ready", 32'(enc_ready), 0);
    check("bp_stable_data", 32'(dec_data), 'h001);
    check("bp_stable_err", 32'(dec_err), 0);
    dec_ready = 1'b1;
    send(13'h1007);
    repeat (4) tick();
    check("bp_drained", 32'(dec_valid), 0);

    // Saturation on the 2-bit instance
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("clr_count", 32'(err_count), 0);
    check("clr_sticky", 32'(err_sticky), 0);
    check("clr_sat_count", 32'(sat_err_count), 0);
    for (int i = 1; i <= 5; i++) begin
      send(make_cw(12'(i * 37), 1'b1));
      check("sat_count", 32'(sat_err_count), (i > 3) ? 3 : i);
      check("wide_count", 32'(err_count), i);
    end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("sat_clr_count", 32'(sat_err_count), 0);
    check("sat_clr_sticky", 32'(sat_err_sticky), 0);
    err_clr = 1'b1;
    send(make_cw(12'h3C4, 1'b1));
    err_clr = 1'b0;
    check("clr_and_err_count", 32'(err_count), 1);
    check("clr_and_err_sticky", 32'(err_sticky), 1);
    check("clr_and_err_sat", 32'(sat_err_count), 1);
    repeat (3) tick();

    // Reset while FULL
    dec_ready = 1'b0;
    send(make_cw(12'h111, 1'b0));
    send(make_cw(12'h222, 1'b1));
    check("full_ready", 32'(enc_ready), 0);
    rst = 1'b1;
    enc_codeword = make_cw(12'h333, 1'b1);
    enc_valid    = 1'b1;
    tick();
    enc_valid = 1'b0;
    rst = 1'b0;
    check("rstfull_dec_valid", 32'(dec_valid), 0);
    check("rstfull_err_count", 32'(err_count), 0);
    check("rstfull_err_sticky", 32'(err_sticky), 0);
    check("rstfull_enc_ready", 32'(enc_ready), 1);
    tick();
    check("rstfull_still_empty", 32'(dec_valid), 0);

    // Traffic after reset
    dec_ready = 1'b1;
    send(make_cw(12'h5A5, 1'b0));
    check("post_rst_valid", 32'(dec_valid), 1);
    check("post_rst_data", 32'(dec_data), 'h5A5);
    repeat (3) tick();
    check("sb_empty", 32'(sb_q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
